// File: rtl/level_rise_state_machine.sv
// Moore FSM converting a rising level transition on X into a one-cycle registered pulse.
// The output is decoded from the state register, so X has no combinational path to it.
module level_rise_state_machine (
  input  logic clk,
  input  logic reset,
  input  logic X,
  output logic output_signal
);

  typedef enum logic [1:0] {
    StLow     = 2'd0,
    StPulse   = 2'd1,
    StHigh    = 2'd2,
    StIllegal = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Reset is synchronous and active-low; it overrides any transition, including mid-pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StLow;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StLow;
    unique case (state_q)
      StLow:     state_d = X ? StPulse : StLow;
      StPulse:   state_d = X ? StHigh  : StLow;
      StHigh:    state_d = X ? StHigh  : StLow;
      StIllegal: state_d = StLow;
      default:   state_d = StLow;
    endcase
  end

  assign output_signal = (state_q == StPulse);

endmodule

// File: tb/tb_level_rise_state_machine.sv
// Table-driven bench with a scoreboard queue for level_rise_state_machine.
module tb_level_rise_state_machine;

  logic clk;
  logic reset;
  logic X;
  logic output_signal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  rst;
    logic  x;
    logic  exp;
    string name;
  } vec_t;

  vec_t vecs[$];
  logic exp_q[$];
  string name_q[$];

  level_rise_state_machine dut (
    .clk           (clk),
    .reset         (reset),
    .X             (X),
    .output_signal (output_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rst, input logic x, input logic exp, input string name);
    vec_t v;
    v.rst  = rst;
    v.x    = x;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endfunction

  // Drive on the falling edge, push the expectation, then compare 1ns after the rising edge.
  task automatic step(input logic rst, input logic x, input logic exp, input string name);
    logic  e;
    string n;
    @(negedge clk);
    reset = rst;
    X     = x;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, output_signal=%0b", name, output_signal);
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (output_signal !== e) begin
        errors++;
        $display("FAIL %s: output_signal=%0b expected %0b", n, output_signal, e);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    X     = 1'b0;

    // Reset held with X low then high
    add(0, 0, 0, "reset_x0");
    add(0, 1, 0, "reset_x1");
    // Basic edge
    add(1, 0, 0, "basic0");
    add(1, 0, 0, "basic1");
    add(1, 1, 1, "basic2");
    add(1, 1, 0, "basic3");
    add(1, 1, 0, "basic4");
    add(1, 1, 0, "basic5");
    // Re-arm
    add(1, 0, 0, "rearm0");
    add(1, 1, 1, "rearm1");
    add(1, 1, 0, "rearm2");
    add(1, 0, 0, "rearm3");
    // Toggle
    add(1, 0, 0, "toggle0");
    add(1, 1, 1, "toggle1");
    add(1, 0, 0, "toggle2");
    add(1, 1, 1, "toggle3");
    add(1, 0, 0, "toggle4");
    // Reset mid-pulse, released with X still high
    add(1, 1, 1, "midrst_pulse");
    add(1, 1, 0, "midrst_dummy_high");
    add(1, 0, 0, "midrst_low");
    add(1, 1, 1, "midrst_rise");
    add(0, 1, 0, "midrst_cut");
    add(1, 1, 1, "midrst_release");
    add(1, 1, 0, "midrst_after");

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].x, vecs[i].exp, vecs[i].name);

    // Long hold: one pulse over 20 high samples
    step(1, 0, 0, "long_lead");
    for (int i = 0; i < 20; i++) begin
      step(1, 1, (i == 0) ? 1'b1 : 1'b0, $sformatf("long_hold%0d", i));
    end

    // Reset while X high from S_HIGH, released with X high: one pulse
    step(0, 1, 0, "rst_high_hold");
    step(1, 1, 1, "rst_high_release");
    step(1, 1, 0, "rst_high_after");

    // Glitch between edges must be ignored
    step(1, 0, 0, "glitch_pre");
    @(negedge clk);
    reset = 1'b1;
    X     = 1'b0;
    exp_q.push_back(1'b0);
    name_q.push_back("glitch");
    #1 X = 1'b1;
    #2 X = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL glitch: scoreboard empty, output_signal=%0b", output_signal);
    end else begin
      logic  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (output_signal !== e) begin
        errors++;
        $display("FAIL %s: output_signal=%0b expected %0b", n, output_signal, e);
      end
    end
    step(1, 0, 0, "glitch_post");
    step(1, 1, 1, "glitch_rise");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
